// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Step counter width: holds 0 .. width-1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor through a ripple-carry adder (inverted divisor, carry-in 1), restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);
  import div_pkg::*;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] carry;

  assign shifted  = {rem, msb_in};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
      assign diff[gi]      = shifted[gi] ^ sub_b[gi] ^ carry[gi];
      assign carry[gi + 1] = (shifted[gi] & sub_b[gi]) |
                             (carry[gi] & (shifted[gi] ^ sub_b[gi]));
    end
  endgenerate

  // Only the carry of the top bit matters: carry-out set means no borrow (t >= 0).
  assign carry[WIDTH + 1] = (shifted[WIDTH] & sub_b[WIDTH]) |
                            (carry[WIDTH] & (shifted[WIDTH] ^ sub_b[WIDTH]));

  assign qbit     = carry[WIDTH + 1];
  assign rem_next = qbit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_div.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_BYPASS_EN: zero divisor skips the iteration and finishes at accept.
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);
  import div_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] qsh_reg, qsh_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             accept;
  logic             deliver;
  logic             y_zero;
  logic             bypass;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .msb_in   (qsh_reg[WIDTH-1]),
    .divisor  (y_reg),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  assign in_ready    = (state_reg == DIV_IDLE);
  assign out_valid   = (state_reg == DIV_DONE);
  assign accept      = in_valid & in_ready;
  assign deliver     = out_valid & out_ready;
  assign y_zero      = (Y == '0);
  assign Q           = qsh_reg;
  assign R           = rem_reg;
  assign div_by_zero = dbz_reg;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = y_zero;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    qsh_next   = qsh_reg;
    y_next     = y_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (accept) begin
          y_next   = Y;
          dbz_next = y_zero;
          cnt_next = '0;
          if (bypass) begin
            // Same result the full iteration would produce for Y == 0.
            qsh_next   = '1;
            rem_next   = X;
            state_next = DIV_DONE;
          end else begin
            qsh_next   = X;
            rem_next   = '0;
            state_next = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_next = step_rem;
        qsh_next = {qsh_reg[WIDTH-2:0], step_qbit};
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (deliver) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      qsh_reg   <= '0;
      y_reg     <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      qsh_reg   <= qsh_next;
      y_reg     <= y_next;
      dbz_reg   <= dbz_next;
    end
  end

endmodule
